// File: rtl/fbc_wr_ch_responder.sv
// fbc_wr_ch_responder
//   Memory-side responder of the FBC burst-write channel. Accepts a burst
//   (req/len/addr) from the write-cache initiator, pulls beats one at a time
//   through a 2-entry buffer, and issues them to a MIG 7-series native port
//   as write-data beats plus one write command per beat. It pulses finish
//   once the whole burst has been handed to the MIG.
//
// Ports
//   clk_i, rst_n_i           ui_clk, asynchronous active-low reset
//   init_calib_complete_i    bursts are accepted only after calibration
//   wr_ddr_req_i/len_i/addr_i burst request (level) with length and base
//   wr_ddr_data_req_o        one-beat pull strobe; data arrives next cycle
//   wr_ddr_data_i            beat data
//   wr_ddr_finish_o          one-cycle burst-complete pulse
//   busy_o                   high whenever not idle
//   app_en/cmd/addr_o, app_rdy_i           MIG command channel
//   app_wdf_wren/end/data/mask_o, app_wdf_rdy_i  MIG write-data channel
module fbc_wr_ch_responder #(
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 512,
  parameter int unsigned ADDR_STEP     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       init_calib_complete_i,
  input  logic                       wr_ddr_req_i,
  input  logic [7:0]                 wr_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]      wr_ddr_addr_i,
  output logic                       wr_ddr_data_req_o,
  input  logic [MEM_DATA_BITS-1:0]   wr_ddr_data_i,
  output logic                       wr_ddr_finish_o,
  output logic                       busy_o,
  output logic                       app_en_o,
  output logic [2:0]                 app_cmd_o,
  output logic [ADDR_WIDTH-1:0]      app_addr_o,
  input  logic                       app_rdy_i,
  output logic                       app_wdf_wren_o,
  output logic                       app_wdf_end_o,
  output logic [MEM_DATA_BITS-1:0]   app_wdf_data_o,
  output logic [MEM_DATA_BITS/8-1:0] app_wdf_mask_o,
  input  logic                       app_wdf_rdy_i
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone, StHold} state_e;

  state_e                   r_state;
  state_e                   w_state_d;
  logic [7:0]               r_len;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [7:0]               r_req_cnt;
  logic [7:0]               r_wdf_cnt;
  logic [7:0]               r_cmd_cnt;
  logic                     r_inflight;

  logic [MEM_DATA_BITS-1:0] r_buf [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_occ;

  logic                     w_start;
  logic                     w_wren;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_en;
  logic                     w_cmd_fire;
  logic                     w_data_req;
  logic [2:0]               w_fill;
  logic [7:0]               w_wdf_cnt_d;
  logic [7:0]               w_cmd_cnt_d;
  logic [ADDR_WIDTH-1:0]    w_addr_off;

  assign w_start    = (r_state == StIdle) && wr_ddr_req_i && init_calib_complete_i;
  assign w_wren     = (r_occ != 2'd0);
  assign w_pop      = w_wren && app_wdf_rdy_i;
  assign w_push     = r_inflight;
  // Commands trail data: only beats already handed to the MIG may be addressed.
  assign w_en       = (r_cmd_cnt < r_wdf_cnt);
  assign w_cmd_fire = w_en && app_rdy_i;

  // A beat already requested occupies a slot; a pop this cycle frees one.
  assign w_fill     = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_data_req = (r_state == StBurst) && (r_req_cnt < r_len) &&
                      (w_fill < (3'd2 + {2'b00, w_pop}));

  assign w_wdf_cnt_d = r_wdf_cnt + {7'd0, w_pop};
  assign w_cmd_cnt_d = r_cmd_cnt + {7'd0, w_cmd_fire};

  assign w_addr_off = ADDR_WIDTH'({24'd0, r_cmd_cnt} * ADDR_STEP);

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = (wr_ddr_len_i == 8'd0) ? StDone : StBurst;
        end
      end
      // Look at next-cycle counts so finish follows the last command directly.
      StBurst: begin
        if ((w_wdf_cnt_d == r_len) && (w_cmd_cnt_d == r_len)) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StHold;
      StHold:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Burst registers and counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_len      <= 8'd0;
      r_base     <= '0;
      r_req_cnt  <= 8'd0;
      r_wdf_cnt  <= 8'd0;
      r_cmd_cnt  <= 8'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_data_req;
      if (w_start) begin
        r_len     <= wr_ddr_len_i;
        r_base    <= wr_ddr_addr_i;
        r_req_cnt <= 8'd0;
        r_wdf_cnt <= 8'd0;
        r_cmd_cnt <= 8'd0;
      end else begin
        if (w_data_req) begin
          r_req_cnt <= r_req_cnt + 8'd1;
        end
        r_wdf_cnt <= w_wdf_cnt_d;
        r_cmd_cnt <= w_cmd_cnt_d;
      end
    end
  end

  // Two-entry beat buffer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= wr_ddr_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign wr_ddr_data_req_o = w_data_req;
  assign wr_ddr_finish_o   = (r_state == StDone);
  assign busy_o            = (r_state != StIdle);

  assign app_en_o          = w_en;
  assign app_cmd_o         = 3'b000;
  assign app_addr_o        = r_base + w_addr_off;

  assign app_wdf_wren_o    = w_wren;
  assign app_wdf_end_o     = w_wren;
  assign app_wdf_data_o    = r_buf[r_rd_ptr];
  assign app_wdf_mask_o    = '0;

endmodule

// File: tb/tb_fbc_wr_ch_responder.sv
// Bench for fbc_wr_ch_responder: scoreboard of expected beats and command
// addresses, a model initiator FIFO feeding data on request, and per-scenario
// tasks checking latency, counts and reset behaviour.
module tb_fbc_wr_ch_responder;
  localparam int AW = 30;
  localparam int DW = 512;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          init_calib_complete_i;
  logic          wr_ddr_req_i;
  logic [7:0]    wr_ddr_len_i;
  logic [AW-1:0] wr_ddr_addr_i;
  logic          wr_ddr_data_req_o;
  logic [DW-1:0] wr_ddr_data_i;
  logic          wr_ddr_finish_o;
  logic          busy_o;
  logic          app_en_o;
  logic [2:0]    app_cmd_o;
  logic [AW-1:0] app_addr_o;
  logic          app_rdy_i;
  logic          app_wdf_wren_o;
  logic          app_wdf_end_o;
  logic [DW-1:0] app_wdf_data_o;
  logic [DW/8-1:0] app_wdf_mask_o;
  logic          app_wdf_rdy_i;

  fbc_wr_ch_responder #(
    .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .ADDR_STEP(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .init_calib_complete_i(init_calib_complete_i),
    .wr_ddr_req_i(wr_ddr_req_i), .wr_ddr_len_i(wr_ddr_len_i), .wr_ddr_addr_i(wr_ddr_addr_i),
    .wr_ddr_data_req_o(wr_ddr_data_req_o), .wr_ddr_data_i(wr_ddr_data_i),
    .wr_ddr_finish_o(wr_ddr_finish_o), .busy_o(busy_o), .app_en_o(app_en_o),
    .app_cmd_o(app_cmd_o), .app_addr_o(app_addr_o), .app_rdy_i(app_rdy_i),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_rdy_i(app_wdf_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  int acc_data = 0;
  int acc_cmd  = 0;
  int src_tag  = 0;
  int src_idx  = 0;
  bit bp_mode  = 1'b0;
  int bp_cnt   = 0;
  bit dp_pend;

  function automatic logic [DW-1:0] beat_val(input int tag, input int idx);
    logic [31:0] w;
    w = 32'((tag << 16) | idx);
    return {16{w}};
  endfunction

  // Model initiator FIFO: a beat appears the cycle after each data_req.
  initial begin
    wr_ddr_data_i = '0;
    forever begin
      @(negedge clk_i);
      dp_pend = wr_ddr_data_req_o && rst_n_i;
      @(posedge clk_i);
      #1;
      if (dp_pend) begin
        wr_ddr_data_i = beat_val(src_tag, src_idx);
        src_idx++;
      end
    end
  end

  // MIG ready driver: both high, or wdf_rdy toggling with an app_rdy gap.
  initial begin
    app_rdy_i     = 1'b1;
    app_wdf_rdy_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (bp_mode) begin
        app_wdf_rdy_i = ~app_wdf_rdy_i;
        app_rdy_i     = !(bp_cnt >= 6 && bp_cnt < 11);
        bp_cnt++;
      end else begin
        app_wdf_rdy_i = 1'b1;
        app_rdy_i     = 1'b1;
      end
    end
  end

  // Scoreboard monitor: pops expectations on each MIG handshake.
  bit            mon_pend;
  int            mon_occ;
  bit            st_w;
  bit            st_c;
  logic [DW-1:0] st_wd;
  logic [AW-1:0] st_ca;
  logic [DW-1:0] e_d;
  logic [AW-1:0] e_a;
  initial begin
    mon_pend = 0; mon_occ = 0; st_w = 0; st_c = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        mon_pend = 0; mon_occ = 0; st_w = 0; st_c = 0; acc_data = 0; acc_cmd = 0;
      end else begin
        if (st_w) begin
          n_checks++;
          if (app_wdf_wren_o !== 1'b1 || app_wdf_data_o !== st_wd) begin
            n_fail++;
            $display("FAIL wdf_hold got wren=%0b data=%h want wren=1 data=%h",
                     app_wdf_wren_o, app_wdf_data_o[31:0], st_wd[31:0]);
          end
        end
        if (st_c) begin
          n_checks++;
          if (app_en_o !== 1'b1 || app_addr_o !== st_ca) begin
            n_fail++;
            $display("FAIL cmd_hold got en=%0b addr=%h want en=1 addr=%h",
                     app_en_o, app_addr_o, st_ca);
          end
        end
        n_checks++;
        if (app_wdf_wren_o !== (mon_occ != 0) || app_wdf_end_o !== app_wdf_wren_o) begin
          n_fail++;
          $display("FAIL wren_occ got wren=%0b end=%0b want %0b (occ=%0d)",
                   app_wdf_wren_o, app_wdf_end_o, (mon_occ != 0), mon_occ);
        end
        if (app_wdf_wren_o && app_wdf_rdy_i) begin
          n_checks++;
          if (exp_data.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra got data=%h want no beat", app_wdf_data_o[31:0]);
          end else begin
            e_d = exp_data.pop_front();
            if (app_wdf_data_o !== e_d || app_wdf_mask_o !== '0) begin
              n_fail++;
              $display("FAIL beat_data got %h mask=%h want %h mask=0",
                       app_wdf_data_o[31:0], app_wdf_mask_o[7:0], e_d[31:0]);
            end
          end
          acc_data++;
        end
        if (app_en_o && app_rdy_i) begin
          n_checks++;
          if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_extra got addr=%h want no command", app_addr_o);
          end else begin
            e_a = exp_addr.pop_front();
            if (app_addr_o !== e_a || app_cmd_o !== 3'b000) begin
              n_fail++;
              $display("FAIL cmd_addr got addr=%h cmd=%0d want addr=%h cmd=0",
                       app_addr_o, app_cmd_o, e_a);
            end
          end
          acc_cmd++;
        end
        n_checks++;
        if (acc_cmd > acc_data) begin
          n_fail++;
          $display("FAIL cmd_lead got cmds=%0d want <= beats=%0d", acc_cmd, acc_data);
        end
        mon_occ = mon_occ + int'(mon_pend) - int'(app_wdf_wren_o && app_wdf_rdy_i);
        n_checks++;
        if (mon_occ > 2 || mon_occ < 0) begin
          n_fail++;
          $display("FAIL occupancy got %0d want 0..2", mon_occ);
        end
        mon_pend = wr_ddr_data_req_o;
        st_w  = app_wdf_wren_o && !app_wdf_rdy_i;
        st_wd = app_wdf_data_o;
        st_c  = app_en_o && !app_rdy_i;
        st_ca = app_addr_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input int len, input logic [AW-1:0] addr, input int tag);
    wr_ddr_req_i  = 1'b1;
    wr_ddr_len_i  = 8'(len);
    wr_ddr_addr_i = addr;
    src_tag = tag;
    src_idx = 0;
    for (int i = 0; i < len; i++) exp_data.push_back(beat_val(tag, i));
  endtask

  // Steps max_c cycles after the launch cycle and records event timing.
  task automatic observe(input int max_c, input bit drop_req,
                         output int f_dreq, output int n_dreq, output int f_wren,
                         output int f_en, output int f_fin, output int l_fin,
                         output int n_fin);
    f_dreq = -1; n_dreq = 0; f_wren = -1; f_en = -1; f_fin = -1; l_fin = -1; n_fin = 0;
    for (int c = 1; c <= max_c; c++) begin
      step();
      if (c == 1 && drop_req) wr_ddr_req_i = 1'b0;
      @(negedge clk_i);
      if (wr_ddr_data_req_o) begin
        if (f_dreq < 0) f_dreq = c;
        n_dreq++;
      end
      if (app_wdf_wren_o && f_wren < 0) f_wren = c;
      if (app_en_o && f_en < 0) f_en = c;
      if (wr_ddr_finish_o) begin
        if (f_fin < 0) f_fin = c;
        l_fin = c;
        n_fin++;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({wr_ddr_data_req_o, wr_ddr_finish_o, busy_o, app_en_o, app_wdf_wren_o,
         app_wdf_end_o} !== 6'b0 || app_addr_o !== '0 || app_wdf_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got dreq=%0b fin=%0b busy=%0b en=%0b wren=%0b addr=%h want 0",
               wr_ddr_data_req_o, wr_ddr_finish_o, busy_o, app_en_o, app_wdf_wren_o,
               app_addr_o);
    end
  endtask

  task automatic test_single();
    int fd, nd, fw, fe, ff, lf, nf;
    step();
    launch(1, 30'h100, 1);
    exp_addr.push_back(30'h100);
    observe(8, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (fd != 1 || nd != 1) begin
      n_fail++; $display("FAIL single_dreq got first=%0d n=%0d want first=1 n=1", fd, nd);
    end
    n_checks++;
    if (fw != 3) begin n_fail++; $display("FAIL single_wren got %0d want 3", fw); end
    n_checks++;
    if (fe != 4) begin n_fail++; $display("FAIL single_en got %0d want 4", fe); end
    n_checks++;
    if (ff != 5 || nf != 1) begin
      n_fail++; $display("FAIL single_finish got at=%0d n=%0d want at=5 n=1", ff, nf);
    end
    n_checks++;
    if (busy_o !== 1'b0 || exp_data.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain got busy=%0b beats_left=%0d cmds_left=%0d want 0",
               busy_o, exp_data.size(), exp_addr.size());
    end
  endtask

  task automatic test_long();
    int fd, nd, fw, fe, ff, lf, nf;
    step();
    launch(128, 30'h0, 0);
    for (int i = 0; i < 128; i++) exp_addr.push_back(30'(8 * i));
    observe(140, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (nd != 128) begin n_fail++; $display("FAIL long_dreq got %0d want 128", nd); end
    n_checks++;
    if (ff != 132 || nf != 1) begin
      n_fail++; $display("FAIL long_finish got at=%0d n=%0d want at=132 n=1", ff, nf);
    end
    n_checks++;
    if (busy_o !== 1'b0 || exp_data.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL long_drain got busy=%0b beats_left=%0d cmds_left=%0d want 0",
               busy_o, exp_data.size(), exp_addr.size());
    end
  endtask

  task automatic test_backpressure();
    int fd, nd, fw, fe, ff, lf, nf, a0, c0;
    step();
    bp_cnt  = 0;
    bp_mode = 1'b1;
    a0 = acc_data;
    c0 = acc_cmd;
    launch(16, 30'h2000, 2);
    for (int i = 0; i < 16; i++) exp_addr.push_back(30'h2000 + 30'(8 * i));
    observe(100, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    bp_mode = 1'b0;
    n_checks++;
    if (nd != 16 || nf != 1) begin
      n_fail++; $display("FAIL bp_counts got dreq=%0d fin=%0d want 16 and 1", nd, nf);
    end
    n_checks++;
    if (acc_data - a0 != 16 || acc_cmd - c0 != 16) begin
      n_fail++;
      $display("FAIL bp_accepts got beats=%0d cmds=%0d want 16/16", acc_data - a0, acc_cmd - c0);
    end
    n_checks++;
    if (busy_o !== 1'b0 || exp_data.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain got busy=%0b beats_left=%0d cmds_left=%0d want 0",
               busy_o, exp_data.size(), exp_addr.size());
    end
  endtask

  task automatic test_wrap();
    int fd, nd, fw, fe, ff, lf, nf;
    step();
    launch(4, 30'h3FFF_FFF0, 3);
    exp_addr.push_back(30'h3FFF_FFF0);
    exp_addr.push_back(30'h3FFF_FFF8);
    exp_addr.push_back(30'h0);
    exp_addr.push_back(30'h8);
    observe(12, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (ff != 8 || nf != 1 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL wrap got finish_at=%0d n=%0d cmds_left=%0d want 8/1/0",
               ff, nf, exp_addr.size());
    end
  endtask

  task automatic test_len0();
    int fd, nd, fw, fe, ff, lf, nf;
    step();
    launch(0, 30'h40, 4);
    observe(5, 1'b0, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (nd != 0 || fw != -1 || fe != -1) begin
      n_fail++; $display("FAIL len0_traffic got dreq=%0d wren_at=%0d en_at=%0d want none",
                         nd, fw, fe);
    end
    n_checks++;
    if (ff != 1 || lf != 4 || nf != 2) begin
      n_fail++; $display("FAIL len0_finish got first=%0d last=%0d n=%0d want 1/4/2", ff, lf, nf);
    end
    observe(4, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (nf != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL len0_idle got fin=%0d busy=%0b want 0/0", nf, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int fd, nd, fw, fe, ff, lf, nf, a0;
    bit reached;
    step();
    a0 = acc_data;
    launch(10, 30'h500, 5);
    for (int i = 0; i < 10; i++) exp_addr.push_back(30'h500 + 30'(8 * i));
    reached = 1'b0;
    for (int c = 1; c <= 40 && !reached; c++) begin
      step();
      if (c == 1) wr_ddr_req_i = 1'b0;
      @(negedge clk_i);
      if (acc_data - a0 >= 5) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL rst_progress got <5 beats want 5"); end
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({wr_ddr_data_req_o, wr_ddr_finish_o, busy_o, app_en_o, app_wdf_wren_o,
         app_wdf_end_o} !== 6'b0 || app_addr_o !== '0 || app_wdf_data_o !== '0) begin
      n_fail++;
      $display("FAIL rst_async got dreq=%0b fin=%0b busy=%0b en=%0b wren=%0b addr=%h want 0",
               wr_ddr_data_req_o, wr_ddr_finish_o, busy_o, app_en_o, app_wdf_wren_o,
               app_addr_o);
    end
    exp_data.delete();
    exp_addr.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b1;
    observe(4, 1'b0, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (nf != 0 || busy_o !== 1'b0 || nd != 0) begin
      n_fail++; $display("FAIL rst_quiet got fin=%0d busy=%0b dreq=%0d want 0", nf, busy_o, nd);
    end
    step();
    launch(2, 30'h600, 6);
    exp_addr.push_back(30'h600);
    exp_addr.push_back(30'h608);
    observe(10, 1'b1, fd, nd, fw, fe, ff, lf, nf);
    n_checks++;
    if (ff != 6 || nf != 1 || nd != 2 || exp_data.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL rst_after got fin_at=%0d n=%0d dreq=%0d left=%0d/%0d want 6/1/2/0/0",
               ff, nf, nd, exp_data.size(), exp_addr.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i               = 1'b0;
    init_calib_complete_i = 1'b1;
    wr_ddr_req_i          = 1'b0;
    wr_ddr_len_i          = 8'd0;
    wr_ddr_addr_i         = '0;
    #2;
    test_reset();
    repeat (2) step();
    rst_n_i = 1'b1;
    test_single();
    test_long();
    test_backpressure();
    test_wrap();
    test_len0();
    test_reset_mid();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
